// File: rtl/ccg_bist_driver_if.sv
`default_nettype none
// ============================================================================
//  Module   : ccg_bist_driver_if
//  Brief    : Control, status and circuit-side signals of the BIST driver.
//             Optional abort input is present when CCG_BIST_ABORT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
interface ccg_bist_driver_if #(
    parameter int N_IN  = 29,
    parameter int N_OUT = 21
);
    logic              start;
    logic [N_IN-1:0]   seed;
    logic [N_OUT-1:0]  golden_sig;
    logic [N_IN-1:0]   x_drive;
    logic [N_OUT-1:0]  f_resp;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_OUT-1:0]  signature;
`ifdef CCG_BIST_ABORT_EN
    logic              abort;

    modport master (
        output start, seed, golden_sig, f_resp, abort,
        input  x_drive, busy, done, pass, signature
    );
    modport slave (
        input  start, seed, golden_sig, f_resp, abort,
        output x_drive, busy, done, pass, signature
    );
`else
    modport master (
        output start, seed, golden_sig, f_resp,
        input  x_drive, busy, done, pass, signature
    );
    modport slave (
        input  start, seed, golden_sig, f_resp,
        output x_drive, busy, done, pass, signature
    );
`endif
endinterface
`default_nettype wire

// File: rtl/ccg_bist_driver.sv
`default_nettype none
// ============================================================================
//  Module   : ccg_bist_driver
//  Brief    : LFSR pattern driver + MISR compactor for a combinational circuit
//             under test; compares the final signature with a golden value.
//             Define CCG_BIST_ABORT_EN to add the abort input.
//  Revision : 1.0 - initial release
// ============================================================================
module ccg_bist_driver #(
    parameter int              N_IN     = 29,
    parameter int              N_OUT    = 21,
    parameter int              PAT_CNT  = 1024,
    parameter int              SETTLE   = 1,
    parameter logic [N_IN-1:0] LFSR_TAP = 29'h1400_0000,
    parameter logic [N_OUT-1:0] MISR_TAP = 21'h14_0000
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    ccg_bist_driver_if.slave   bus
);

    localparam int c_PW = $clog2(PAT_CNT + 1);
    localparam int c_SW = $clog2(SETTLE + 1);
    localparam logic [c_PW-1:0] c_PAT_LAST = c_PW'(PAT_CNT - 1);
    localparam logic [c_SW-1:0] c_SET_LAST = c_SW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SETTLE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [N_IN-1:0]   r_lfsr;
    logic [N_OUT-1:0]  r_misr;
    logic [c_PW-1:0]   r_pat_cnt;
    logic [c_SW-1:0]   r_set_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic              w_abort;

`ifdef CCG_BIST_ABORT_EN
    assign w_abort = bus.abort && (r_state inside {S_LOAD, S_SETTLE, S_CAPTURE});
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.start) w_next = S_LOAD;
            S_LOAD:    w_next = S_SETTLE;
            S_SETTLE:  if (r_set_cnt == c_SET_LAST) w_next = S_CAPTURE;
            S_CAPTURE: w_next = (r_pat_cnt == c_PAT_LAST) ? S_FINISH : S_SETTLE;
            S_FINISH:  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    // Status flags are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr    <= '0;
            r_misr    <= '0;
            r_pat_cnt <= '0;
            r_set_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_busy    <= (w_next == S_SETTLE) || (w_next == S_CAPTURE);
            r_done    <= (w_next == S_FINISH);
            r_set_cnt <= ((r_state == S_SETTLE) && (w_next == S_SETTLE)) ?
                         r_set_cnt + 1'b1 : '0;
            if (w_abort) begin
                r_pass <= 1'b0;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        r_lfsr    <= (bus.seed == '0) ? N_IN'(1) : bus.seed;
                        r_misr    <= '0;
                        r_pat_cnt <= '0;
                        r_pass    <= 1'b0;
                    end
                    S_CAPTURE: begin
                        r_misr    <= {r_misr[N_OUT-2:0], ^(r_misr & MISR_TAP)} ^ bus.f_resp;
                        r_lfsr    <= {r_lfsr[N_IN-2:0], ^(r_lfsr & LFSR_TAP)};
                        r_pat_cnt <= r_pat_cnt + 1'b1;
                    end
                    S_FINISH: begin
                        r_pass <= (r_misr == bus.golden_sig);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.x_drive   = r_lfsr;
    assign bus.signature = r_misr;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;

endmodule
`default_nettype wire
